// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: Res = A - B computed LSB first, one bit per clock,
// through a single full-subtractor cell with a registered borrow.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Res,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    count;
  logic             bw;
  logic             a_msb;
  logic             b_msb;

  logic             d;
  logic             bw_next;
  logic [WIDTH-1:0] res_next;

  // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ bw;
    bw_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    res_next = {d, res_sr[WIDTH-1:1]};
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      count  <= '0;
      bw     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      Res    <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
      Z      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            res_sr <= '0;
            count  <= '0;
            bw     <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          bw     <= bw_next;
          count  <= count + 1'b1;
          // The final bit lands in the MSB of res_next, so flags come from it directly.
          if (count == LAST) begin
            Res   <= res_next;
            Bout  <= bw_next;
            V     <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
            Z     <= (res_next == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench: a WIDTH=4 and a WIDTH=8 subtractor run side by side;
// expected results come from integer arithmetic and are popped on each done pulse.
module tb_serial_ripple_subtractor;

  typedef struct {
    int res;
    int bout;
    int v;
    int z;
    int done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [7:0] a_in, b_in;

  logic [3:0] res4;
  logic       bout4, v4, z4, busy4, done4;
  logic [7:0] res8;
  logic       bout8, v8, z8, busy8, done8;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   hold4 = 0;
  int   hold8 = 0;
  exp_t q4[$];
  exp_t q8[$];

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a_in[3:0]), .B(b_in[3:0]),
    .Res(res4), .Bout(bout4), .V(v4), .Z(z4), .busy(busy4), .done(done4)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a_in), .B(b_in),
    .Res(res8), .Bout(bout8), .V(v8), .Z(z8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: modular difference, unsigned borrow, signed range overflow.
  function automatic exp_t model(input int w, input int a, input int b, input int acc);
    exp_t e;
    int   mask, sa, sb, diff;
    mask = (1 << w) - 1;
    a    = a & mask;
    b    = b & mask;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    diff = sa - sb;
    e.res      = (a - b) & mask;
    e.bout     = (a < b) ? 1 : 0;
    e.v        = (diff > (1 << (w - 1)) - 1 || diff < -(1 << (w - 1))) ? 1 : 0;
    e.z        = (e.res == 0) ? 1 : 0;
    e.done_cyc = acc + w;
    return e;
  endfunction

  // Monitors: pop and compare on every done pulse; RUN must not disturb held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      check("busy4_with_done", int'(busy4), 1);
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 1, 0);
      end else begin
        e = q4.pop_front();
        check("w4_res", int'(res4), e.res);
        check("w4_bout", int'(bout4), e.bout);
        check("w4_v", int'(v4), e.v);
        check("w4_z", int'(z4), e.z);
        check("w4_latency", cyc, e.done_cyc);
        hold4 = int'(res4);
      end
    end else if (busy4) begin
      check("w4_res_held", int'(res4), hold4);
    end else begin
      check("w4_done_in_idle", int'(done4), 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check("busy8_with_done", int'(busy8), 1);
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        check("w8_res", int'(res8), e.res);
        check("w8_bout", int'(bout8), e.bout);
        check("w8_v", int'(v8), e.v);
        check("w8_z", int'(z8), e.z);
        check("w8_latency", cyc, e.done_cyc);
        hold8 = int'(res8);
      end
    end else if (busy8) begin
      check("w8_res_held", int'(res8), hold8);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy4 || busy8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy4 || busy8) check("idle_timeout", 1, 0);
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!done4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done4) check("done4_timeout", 0, 1);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("done8_timeout", 0, 1);
  endtask

  // Returns at the negedge right after the accepting edge.
  task automatic issue(input int a, input int b);
    wait_idle();
    a_in   = 8'(a);
    b_in   = 8'(b);
    start4 = 1'b1;
    start8 = 1'b1;
    q4.push_back(model(4, a, b, cyc + 1));
    q8.push_back(model(8, a, b, cyc + 1));
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res4"}, int'(res4), 0);
    check({tag, "_flags4"}, int'({bout4, v4, z4, busy4, done4}), 0);
    check({tag, "_res8"}, int'(res8), 0);
    check({tag, "_flags8"}, int'({bout8, v8, z8, busy8, done8}), 0);
  endtask

  initial begin
    rst    = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    issue(7, 3);
    issue(3, 7);
    issue(8, 1);
    issue(5, 5);
    issue(255, 0);
    issue(0, 255);
    issue(128, 1);
    issue(127, 255);

    // Starts during RUN and during each DONE must be ignored.
    issue(9, 2);
    start4 = 1'b1;
    start8 = 1'b1;
    a_in   = 8'd0;
    b_in   = 8'd1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    wait_done4();
    start4 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    wait_done8();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;

    // Abort mid-operation: rst on the second edge after acceptance.
    issue(6, 1);
    rst = 1'b1;
    q4.delete();
    q8.delete();
    @(negedge clk);
    check_all_zero("abort");
    hold4 = 0;
    hold8 = 0;
    rst   = 1'b0;
    issue(2, 2);

    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    wait_idle();
    repeat (20) @(negedge clk);
    check("w4_queue_drained", q4.size(), 0);
    check("w8_queue_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
Multi-cycle, bit-serial subtractor that computes Res = A - B one bit per clock. It propagates a borrow through a single full-subtractor cell, the counterpart of the ripple-carry adder datapath. It serves the ALU's subtract path where area matters more than latency. Operands are captured on a start/busy/done handshake. Result and flags are held until the next accepted operation.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request pulse; accepted only in IDLE
A  input  WIDTH  minuend; sampled on the accepting edge only
B  input  WIDTH  subtrahend; sampled on the accepting edge only
Res  output  WIDTH  difference A-B mod 2^WIDTH; registered
Bout  output  1  final borrow; 1 iff A < B unsigned
V  output  1  signed overflow of A-B (two's complement)
Z  output  1  1 iff Res == 0
busy  output  1  high in RUN and DONE states
done  output  1  single-cycle pulse; Res/flags valid

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE; Res=0, Bout=0, V=0, Z=0, busy=0, done=0; internal shift registers, bit counter and borrow cleared.
- rst has priority over every other input. Asserting rst mid-operation aborts it with no partial result retained.
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1, latch A and B into shift registers, set bit counter=0 and borrow=0, then go to RUN. With start=0, stay in IDLE and hold outputs.
- RUN: on each edge, process bit i (LSB first):
  - d = a_i ^ b_i ^ bw
  - bw_next = (~a_i & b_i) | (~(a_i ^ b_i) & bw)
  - shift d into the result shift register from the MSB side; shift the operand registers right.
  - increment the counter.
  - On the edge that processes bit WIDTH-1, load Res, Bout=bw_next, V, Z, and go to DONE.
- V = (A[MSB] != B[MSB]) && (Res[MSB] != A[MSB]), using the latched operand MSBs.
- Z is computed from the final Res value.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE.
- Latency: start accepted at edge k. Res/flags update at edge k+WIDTH. done is high between edges k+WIDTH and k+WIDTH+1. The next start can be accepted at edge k+WIDTH+1 at the earliest.
- start while busy=1 (RUN or DONE) is ignored entirely: no re-latch and no queuing. A and B changing during RUN has no effect.
- Res, Bout, V and Z change only on the completing edge or on reset. They are stable across IDLE and during the next RUN until its completion.
- busy=0 only in IDLE. done is never high in IDLE or RUN.
- Counter width is clog2(WIDTH)+1. No wrap occurs because the transition to DONE happens at count WIDTH-1.

Test Plan:
- WIDTH=4, reset, then start with A=7, B=3 -> done pulse 4 edges after acceptance; Res=4, Bout=0, V=0, Z=0; busy high for 5 cycles.
- A=3, B=7 -> Res=12 (4'b1100), Bout=1, V=0, Z=0.
- A=8 (-8), B=1 -> Res=7, Bout=0, V=1. Then A=5, B=5 -> Res=0, Z=1, Bout=0, V=0.
- A=9, B=2 accepted; pulse start again with A=0, B=1 during RUN and during DONE -> both ignored; Res=7 and exactly one done pulse.
- A=6, B=1 accepted; assert rst two edges later -> next cycle all outputs 0, busy=0, no done. A fresh start with A=2, B=2 -> Res=0, Z=1.
- WIDTH=8: A=255, B=0 -> Res=255, Bout=0, V=0. Then A=0, B=255 -> Res=1, Bout=1. done arrives 8 edges after acceptance in both cases.
